// File: rtl/move_decoder.sv
// move_decoder: parses the opponent's ASCII move ("Sxxyy" or "Mxxyyxxyy")
// into zero-based board coordinates for game_board. It validates each
// message and holds off the byte stream until the board stage reports that
// our reply has been computed.
module move_decoder #(
   parameter int unsigned BOARD_SIZE = 19,
   parameter logic [5:0]  NO_STONE   = 6'h3F
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       move_done,
   output logic [5:0] x_1,
   output logic [5:0] y_1,
   output logic [5:0] x_2,
   output logic [5:0] y_2,
   output logic [1:0] stone_count,
   output logic       compute_move,
   output logic       err,
   output logic [7:0] move_count
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DIGITS    = 3'd1,
      CHECK     = 3'd2,
      PLACE     = 3'd3,
      WAIT_DONE = 3'd4
   } state_t;

   localparam logic [7:0] CMD_SINGLE = 8'h53;   // 'S'
   localparam logic [7:0] CMD_DOUBLE = 8'h4D;   // 'M'
   localparam logic [5:0] BOARD_MAX  = 6'(BOARD_SIZE);

   // ASCII '0'..'9'
   function automatic logic is_digit(input logic [7:0] b);
      return (b >= 8'h30) && (b <= 8'h39);
   endfunction

   // One-based coordinate outside 1..BOARD_SIZE
   function automatic logic coord_bad(input logic [4:0] c);
      return (c == 5'd0) || ({1'b0, c} > BOARD_MAX);
   endfunction

   // One-based 5-bit value to zero-based 6-bit output coordinate
   function automatic logic [5:0] zero_based(input logic [4:0] c);
      logic [4:0] z;
      z = c - 5'd1;
      return {1'b0, z};
   endfunction

   state_t     state;
   state_t     state_nxt;
   logic       two_stones;
   logic [2:0] last_idx;
   logic [2:0] digit_idx;
   logic       tens;
   logic [4:0] coord [4];

   logic       accept;
   logic       err_nxt;
   logic       load_cmd;
   logic       cmd_two;
   logic       digit_store;
   logic       place_go;
   logic       check_fail;
   logic       dup_stone;
   logic [4:0] unit_value;

   assign accept     = in_valid & in_ready;
   // tens digit is already restricted to 0/1, so value never exceeds 19
   assign unit_value = (tens ? 5'd10 : 5'd0) + {1'b0, in_data[3:0]};
   assign dup_stone  = (coord[0] == coord[2]) && (coord[1] == coord[3]);

   // Range and duplicate check on the fully parsed message
   always_comb begin
      check_fail = coord_bad(coord[0]) | coord_bad(coord[1]);
      if (two_stones) begin
         check_fail = check_fail | coord_bad(coord[2]) | coord_bad(coord[3]) | dup_stone;
      end else begin
         check_fail = check_fail;
      end
   end

   // Next-state and per-cycle control decode
   always_comb begin
      state_nxt   = state;
      err_nxt     = 1'b0;
      load_cmd    = 1'b0;
      cmd_two     = 1'b0;
      digit_store = 1'b0;
      place_go    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (in_data == CMD_SINGLE) begin
                  load_cmd  = 1'b1;
                  cmd_two   = 1'b0;
                  state_nxt = DIGITS;
               end else if (in_data == CMD_DOUBLE) begin
                  load_cmd  = 1'b1;
                  cmd_two   = 1'b1;
                  state_nxt = DIGITS;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         DIGITS: begin
            if (accept) begin
               if (!is_digit(in_data)) begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end else if (!digit_idx[0] && (in_data[3:0] > 4'd1)) begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  digit_store = 1'b1;
                  if (digit_idx == last_idx) begin
                     state_nxt = CHECK;
                  end else begin
                     state_nxt = DIGITS;
                  end
               end
            end else begin
               state_nxt = DIGITS;
            end
         end
         CHECK: begin
            if (check_fail) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               place_go  = 1'b1;
               state_nxt = PLACE;
            end
         end
         PLACE: begin
            state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (move_done) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = WAIT_DONE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register plus handshake/status outputs registered from the state being entered
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         in_ready     <= 1'b1;
         compute_move <= 1'b1;
         err          <= 1'b0;
      end else begin
         state        <= state_nxt;
         in_ready     <= (state_nxt == IDLE) || (state_nxt == DIGITS);
         compute_move <= (state_nxt != PLACE);
         err          <= err_nxt;
      end
   end

   // Message parser: command type, digit position and accumulated coordinates
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         two_stones <= 1'b0;
         last_idx   <= 3'd0;
         digit_idx  <= 3'd0;
         tens       <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            coord[i] <= 5'd0;
         end
      end else if (load_cmd) begin
         two_stones <= cmd_two;
         last_idx   <= cmd_two ? 3'd7 : 3'd3;
         digit_idx  <= 3'd0;
         tens       <= 1'b0;
      end else if (digit_store) begin
         digit_idx <= digit_idx + 3'd1;
         if (!digit_idx[0]) begin
            tens <= in_data[0];
         end else begin
            coord[digit_idx[2:1]] <= unit_value;
         end
      end else begin
         digit_idx <= digit_idx;
      end
   end

   // Board-facing coordinates and move counter, loaded only when a message passes the check
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_1         <= NO_STONE;
         y_1         <= NO_STONE;
         x_2         <= NO_STONE;
         y_2         <= NO_STONE;
         stone_count <= 2'd0;
         move_count  <= 8'd0;
      end else if (place_go) begin
         x_1 <= zero_based(coord[0]);
         y_1 <= zero_based(coord[1]);
         if (two_stones) begin
            x_2         <= zero_based(coord[2]);
            y_2         <= zero_based(coord[3]);
            stone_count <= 2'd2;
         end else begin
            x_2         <= NO_STONE;
            y_2         <= NO_STONE;
            stone_count <= 2'd1;
         end
         if (move_count != 8'hFF) begin
            move_count <= move_count + 8'd1;
         end else begin
            move_count <= move_count;
         end
      end else begin
         move_count <= move_count;
      end
   end

endmodule

// File: tb/tb_move_decoder.sv
// tb_move_decoder: table-driven directed bench for move_decoder, plus
// hand-written sequences for back-pressure, move_done timing, reset and
// move counter saturation.
module tb_move_decoder;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       move_done;
   logic [5:0] x_1, y_1, x_2, y_2;
   logic [1:0] stone_count;
   logic       compute_move;
   logic       err;
   logic [7:0] move_count;

   always #5 clk = ~clk;

   move_decoder #(.BOARD_SIZE(19), .NO_STONE(6'h3F)) dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .move_done(move_done),
      .x_1(x_1), .y_1(y_1), .x_2(x_2), .y_2(y_2),
      .stone_count(stone_count), .compute_move(compute_move),
      .err(err), .move_count(move_count)
   );

   typedef struct packed {
      logic [71:0] msg;      // byte i at msg[8*i +: 8]
      logic [3:0]  len;
      logic        ok;
      logic [1:0]  err_cyc;  // cycle after last byte where err is high (0 = never)
      logic [5:0]  x1, y1, x2, y2;
      logic [1:0]  sc;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   int total = 0;
   int bad   = 0;

   // expected held outputs
   logic [5:0] ex1, ey1, ex2, ey2;
   logic [1:0] esc;
   int         emc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string s, input logic ok, input logic [1:0] ec,
                               input logic [5:0] x1, input logic [5:0] y1,
                               input logic [5:0] x2, input logic [5:0] y2,
                               input logic [1:0] sc);
      vec_t v;
      v.msg = '0;
      v.len = 4'(s.len());
      for (int i = 0; i < s.len(); i++) v.msg[8*i +: 8] = s[i];
      v.ok = ok; v.err_cyc = ec;
      v.x1 = x1; v.y1 = y1; v.x2 = x2; v.y2 = y2; v.sc = sc;
      return v;
   endfunction

   // Starts and ends at a falling edge; returns in the cycle after acceptance.
   task automatic send_byte(input logic [7:0] b);
      int waited;
      waited   = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (in_ready !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL send_byte: in_ready=%b after 200 cycles, expected 1", in_ready);
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, " x_1"}, x_1, ex1);
      chk({tag, " y_1"}, y_1, ey1);
      chk({tag, " x_2"}, x_2, ex2);
      chk({tag, " y_2"}, y_2, ey2);
      chk({tag, " stone_count"}, stone_count, esc);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      string tag;
      for (int i = 0; i < int'(v.len); i++) send_byte(v.msg[8*i +: 8]);
      in_valid = 1'b0;
      if (v.ok) begin
         ex1 = v.x1; ey1 = v.y1; ex2 = v.x2; ey2 = v.y2; esc = v.sc;
         emc = (emc >= 255) ? 255 : emc + 1;
      end
      for (int k = 1; k <= 4; k++) begin
         tag = $sformatf("v%0d k%0d", idx, k);
         chk({tag, " err"}, err, (k == int'(v.err_cyc)));
         chk({tag, " compute_move"}, compute_move, !(v.ok && k == 2));
         chk({tag, " in_ready"}, in_ready, v.ok ? 1'b0 : (k >= int'(v.err_cyc)));
         if ((v.ok && k == 2) || k == 4) chk_outs(tag);
         if (k == 4) chk({tag, " move_count"}, move_count, emc);
         @(negedge clk);
      end
      if (v.ok) begin
         move_done = 1'b1;
         @(negedge clk);
         move_done = 1'b0;
         chk($sformatf("v%0d ready after done", idx), in_ready, 1'b1);
      end
   endtask

   initial begin
      int acc;
      int lows;
      string m;

      reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; move_done = 1'b0;
      ex1 = 6'h3F; ey1 = 6'h3F; ex2 = 6'h3F; ey2 = 6'h3F; esc = 2'd0; emc = 0;

      vecs[0]  = mk("M03041018", 1'b1, 2'd0, 6'd2,  6'd3,  6'd9,  6'd17, 2'd2);
      vecs[1]  = mk("S1010",     1'b1, 2'd0, 6'd9,  6'd9,  6'h3F, 6'h3F, 2'd1);
      vecs[2]  = mk("M012",      1'b0, 2'd1, 6'd0,  6'd0,  6'd0,  6'd0,  2'd0);
      vecs[3]  = mk("S0101",     1'b1, 2'd0, 6'd0,  6'd0,  6'h3F, 6'h3F, 2'd1);
      vecs[4]  = mk("M05050505", 1'b0, 2'd2, 6'd0,  6'd0,  6'd0,  6'd0,  2'd0);
      vecs[5]  = mk("S0019",     1'b0, 2'd2, 6'd0,  6'd0,  6'd0,  6'd0,  2'd0);
      vecs[6]  = mk("X",         1'b0, 2'd1, 6'd0,  6'd0,  6'd0,  6'd0,  2'd0);
      vecs[7]  = mk("s",         1'b0, 2'd1, 6'd0,  6'd0,  6'd0,  6'd0,  2'd0);
      vecs[8]  = mk("M01A",      1'b0, 2'd1, 6'd0,  6'd0,  6'd0,  6'd0,  2'd0);
      vecs[9]  = mk("M19190101", 1'b1, 2'd0, 6'd18, 6'd18, 6'd0,  6'd0,  2'd2);
      vecs[10] = mk("S192",      1'b0, 2'd1, 6'd0,  6'd0,  6'd0,  6'd0,  2'd0);
      vecs[11] = mk("M01010102", 1'b1, 2'd0, 6'd0,  6'd0,  6'd0,  6'd1,  2'd2);

      // reset values
      repeat (2) @(negedge clk);
      chk("rst in_ready", in_ready, 1'b1);
      chk("rst compute_move", compute_move, 1'b1);
      chk("rst err", err, 1'b0);
      chk("rst move_count", move_count, 8'd0);
      chk_outs("rst");
      reset_n = 1'b1;
      @(negedge clk);

      // table-driven messages
      for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

      // move_done while idle has no effect
      move_done = 1'b1;
      @(negedge clk);
      move_done = 1'b0;
      chk("idle done in_ready", in_ready, 1'b1);
      chk("idle done compute_move", compute_move, 1'b1);
      chk("idle done err", err, 1'b0);
      chk("idle done move_count", move_count, emc);
      chk_outs("idle done");

      // move_done in the first WAIT_DONE cycle
      m = "S0505";
      for (int i = 0; i < m.len(); i++) send_byte(m[i]);
      in_valid = 1'b0;
      ex1 = 6'd4; ey1 = 6'd4; ex2 = 6'h3F; ey2 = 6'h3F; esc = 2'd1; emc = emc + 1;
      @(negedge clk);
      chk("early done place cm", compute_move, 1'b0);
      chk_outs("early done");
      @(negedge clk);
      chk("early done wait in_ready", in_ready, 1'b0);
      move_done = 1'b1;
      @(negedge clk);
      move_done = 1'b0;
      chk("early done honoured", in_ready, 1'b1);
      chk("early done move_count", move_count, emc);

      // back-to-back bytes held during a 20-cycle wait
      m = "M01020304";
      for (int i = 0; i < m.len(); i++) send_byte(m[i]);
      in_data = 8'h4D;
      in_valid = 1'b1;
      acc = 0;
      lows = 0;
      for (int c = 0; c < 22; c++) begin
         if (in_ready) acc++;
         if (!compute_move) lows++;
         @(negedge clk);
      end
      ex1 = 6'd0; ey1 = 6'd1; ex2 = 6'd2; ey2 = 6'd3; esc = 2'd2; emc = emc + 1;
      chk("hold no accept", acc, 0);
      chk("hold one place cycle", lows, 1);
      chk_outs("hold");
      move_done = 1'b1;
      @(negedge clk);
      move_done = 1'b0;
      chk("hold release in_ready", in_ready, 1'b1);
      run_vec(100, mk("M05060708", 1'b1, 2'd0, 6'd4, 6'd5, 6'd6, 6'd7, 2'd2));

      // asynchronous reset in the middle of a message
      m = "M01020";
      for (int i = 0; i < m.len(); i++) send_byte(m[i]);
      in_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      ex1 = 6'h3F; ey1 = 6'h3F; ex2 = 6'h3F; ey2 = 6'h3F; esc = 2'd0; emc = 0;
      chk("mid rst in_ready", in_ready, 1'b1);
      chk("mid rst compute_move", compute_move, 1'b1);
      chk("mid rst err", err, 1'b0);
      chk("mid rst move_count", move_count, 8'd0);
      chk_outs("mid rst");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_vec(200, vecs[0]);

      // counter saturation
      for (int i = 0; i < 256; i++) run_vec(300 + i, vecs[3]);
      chk("move_count saturated", move_count, 8'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/move_decoder.md
# move_decoder

Upstream front end for `game_board`. Accepts the opponent's move as a stream of ASCII bytes over a valid/ready byte interface and parses it into zero-based board coordinates. It validates each move and drives `x_1`, `y_1`, `x_2`, `y_2` and `compute_move` into `game_board`. It stalls the byte stream until the board stage reports that our reply has been computed.

## Interface
Parameters:
- `BOARD_SIZE`, 19: board edge length. Legal one-based coordinates are 1..BOARD_SIZE.
- `NO_STONE`, 6'h3F: coordinate value driven on `x_2`/`y_2` for a single-stone move.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_data`  in  8: ASCII byte.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: byte is accepted when `in_valid & in_ready` at a rising edge.
- `move_done`  in  1: one-cycle pulse from the board stage; our reply is ready.
- `x_1`, `y_1`, `x_2`, `y_2`  out  6 each: zero-based coordinates (0..18).
- `stone_count`  out  2: 1 or 2 stones in the current move.
- `compute_move`  out  1: 0 = place opponent stones, 1 = compute/idle.
- `err`  out  1: one-cycle pulse on a rejected message.
- `move_count`  out  8: accepted moves, saturating at 255.

## Operation
- Message `S d d d d`: single stone (opening), digits are xx yy.
- Message `M d d d d d d d d`: two stones, digits are xx yy xx yy.
- Each coordinate is two ASCII decimal digits, tens digit first, value 01..19. The stored value is (value − 1).
- Command bytes are case-sensitive. Any other byte in IDLE is rejected.
- FSM states: IDLE, DIGITS, CHECK, PLACE, WAIT_DONE.
  - IDLE: `in_ready`=1. On `S` load a digit count of 4; on `M` load 8; either goes to DIGITS. On any other byte, pulse `err` and stay in IDLE.
  - DIGITS: `in_ready`=1. Each accepted byte:
    - A byte outside '0'..'9' pulses `err` and returns to IDLE, discarding the partial message.
    - A tens digit other than '0'/'1' is rejected the same way.
    - After the last digit, go to CHECK.
  - CHECK: `in_ready`=0.
    - Reject (pulse `err`, return to IDLE, outputs unchanged) if any coordinate is 0 or greater than BOARD_SIZE.
    - For `M`, also reject if both stones have equal (x,y).
    - Otherwise go to PLACE.
  - PLACE: exactly one cycle. Register the new coordinates and `stone_count`. Drive `compute_move`=0. For `S`, drive `x_2`=`y_2`=NO_STONE. Increment `move_count` (saturating).
  - WAIT_DONE: `compute_move`=1, `in_ready`=0. A `move_done` pulse returns the FSM to IDLE.
- `move_done` is ignored in every state except WAIT_DONE.
- Coordinate outputs hold their value until the next successful PLACE.
- Digit arithmetic: value = tens×10 + units, computed in 5 bits (maximum 19). The zero-based result is zero-extended to 6 bits.

## Timing
- Reset values:
  - `in_ready`=1, `compute_move`=1, `err`=0.
  - `x_1`=`y_1`=`x_2`=`y_2`=NO_STONE, `stone_count`=0, `move_count`=0.
  - FSM in IDLE.
- With the last digit accepted at edge N:
  - CHECK occupies cycle N+1.
  - Outputs are updated and `compute_move`=0 during cycle N+2.
  - `compute_move`=1 from N+3.
- `err` is asserted for exactly one cycle:
  - For an illegal byte accepted at edge N, `err` is high in cycle N+1.
  - For a range or duplicate failure, `err` is high in the cycle after CHECK.
- `in_ready` falls in the cycle after the last digit is accepted. It rises in the cycle after `move_done` is sampled in WAIT_DONE.
- A `move_done` pulse arriving in the same cycle the FSM enters WAIT_DONE is honoured.
- `in_valid` with `in_ready`=0 consumes nothing; the byte must be held by the source.
- Asserting `reset_n` mid-message or in WAIT_DONE discards everything and restores all reset values immediately (asynchronously).
- There is no timeout in WAIT_DONE.

## Test plan
- Reset, then send "M03041018" → in cycle N+2: `x_1`=2, `y_1`=3, `x_2`=9, `y_2`=17, `stone_count`=2, `compute_move`=0. From N+3, `compute_move`=1 and `in_ready`=0. A `move_done` pulse → `in_ready`=1 next cycle, `move_count`=1.
- Send "S1010" → `x_1`=`y_1`=9, `x_2`=`y_2`=6'h3F, `stone_count`=1, one-cycle `compute_move` low.
- Send "M0120…" → `err` pulses after the '2' tens digit, FSM is in IDLE, outputs and `move_count` are unchanged. A following "S0101" is accepted normally.
- Send "M05050505" (duplicate) and "S0019" (value 0) → each produces exactly one `err` pulse and no `compute_move` low cycle.
- Hold `in_valid`=1 with "M" bytes back-to-back, and delay `move_done` by 20 cycles → no byte accepted during WAIT_DONE; the second message parses correctly after release. Also check that a `move_done` pulse in IDLE has no effect.
- Assert `reset_n`=0 after 5 digits of an `M` message → all outputs return to reset values immediately; a full subsequent message decodes correctly. Then run 256 valid moves → `move_count` saturates at 255.
